// File: rtl/jt49_bus_sched_pkg.sv
// Shared definitions for the jt49 PSG bus scheduler.
//   - Bus phase codes driven on {bdir,bc1}
//   - FSM state encoding
//   - Latched access payload
//   - Helper that maps a state to its bus phase code
package jt49_bus_sched_pkg;

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DATA_W = 8;

    localparam logic [1:0] BUS_INACT = 2'b00;
    localparam logic [1:0] BUS_READ  = 2'b01;
    localparam logic [1:0] BUS_WRITE = 2'b10;
    localparam logic [1:0] BUS_ADDR  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_GAP1 = 3'd2,
        ST_DATA = 3'd3,
        ST_GAP2 = 3'd4
    } state_e;

    // One accepted register access.
    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } acc_t;

    // Bus phase code shown while the FSM sits in a given state.
    function automatic logic [1:0] phase_code(input state_e st, input logic we);
        logic [1:0] code;
        code = BUS_INACT;
        case (st)
            ST_ADDR: code = BUS_ADDR;
            ST_DATA: code = we ? BUS_WRITE : BUS_READ;
            default: code = BUS_INACT;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/jt49_rr_arb2.sv
// Two-input round-robin arbiter.
// Ports:
//   clk, rst  - clock, synchronous active-high reset (pointer favours port 0)
//   req[1:0]  - request lines
//   adv       - a grant was taken this cycle; pointer moves past the winner
//   gnt[1:0]  - one-hot grant (zero when no request), combinational
//   gidx      - index of the winning port, combinational
module jt49_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       adv,
    output logic [1:0] gnt,
    output logic       gidx
);

    logic ptr;

    // A lone requester always wins; on contention the pointer decides.
    always_comb begin
        gidx = ptr;
        if (req == 2'b01) begin
            gidx = 1'b0;
        end else if (req == 2'b10) begin
            gidx = 1'b1;
        end
        gnt = {gidx, ~gidx} & {2{|req}};
    end

    // Pointer register: after each grant the other port is favoured.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= 1'b0;
        end else if (adv) begin
            ptr <= ~gidx;
        end
    end

endmodule

// File: rtl/jt49_bus_sched.sv
// Register-access sequencer for the jt49 PSG BDIR/BC1/DA bus wrapper.
// Two requesters (port 0 CPU, port 1 replay engine) share the PSG through a
// round-robin arbiter. Each access runs ADDR(HOLD) -> GAP1 -> DATA(HOLD) ->
// GAP2 and reads return the PSG byte tagged with the issuing port.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   req_valid/req_ready - per-port handshake; req_ready pulses in the accept
//                         cycle and is decoded from IDLE + arbiter grant
//   req_we/addr/data    - per-port access fields, sampled on accept
//   rvalid/rid/rdata    - read completion pulse, port tag, held read byte
//   busy                - FSM not idle
//   bdir/bc1/bus_dout   - to jt49_bus; bus_din - from jt49_bus dout
module jt49_bus_sched
    import jt49_bus_sched_pkg::*;
#(
    parameter int unsigned HOLD = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [1:0]  req_we,
    input  logic [7:0]  req_addr,
    input  logic [15:0] req_data,
    output logic        rvalid,
    output logic        rid,
    output logic [7:0]  rdata,
    output logic        busy,
    output logic        bdir,
    output logic        bc1,
    output logic [7:0]  bus_dout,
    input  logic [7:0]  bus_din
);

    localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD - 1);

    state_e           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    acc_t             lat, lat_n;
    logic             lat_g, lat_g_n;

    logic [1:0]       arb_req;
    logic [1:0]       gnt;
    logic             gidx;
    logic             accept;
    acc_t             req_sel;

    logic             bdir_n, bc1_n;
    logic [7:0]       bus_dout_n;
    logic             rvalid_n, rid_n, busy_n;
    logic [7:0]       rdata_n;

    // Requests are only visible to the arbiter while idle and out of reset.
    assign arb_req   = req_valid & {2{(state == ST_IDLE) && !rst}};
    assign accept    = |gnt;
    assign req_ready = gnt;

    jt49_rr_arb2 u_arb (
        .clk  (clk),
        .rst  (rst),
        .req  (arb_req),
        .adv  (accept),
        .gnt  (gnt),
        .gidx (gidx)
    );

    // Fields of the winning port.
    always_comb begin
        req_sel = '0;
        if (gidx) begin
            req_sel.we   = req_we[1];
            req_sel.addr = req_addr[7:4];
            req_sel.data = req_data[15:8];
        end else begin
            req_sel.we   = req_we[0];
            req_sel.addr = req_addr[3:0];
            req_sel.data = req_data[7:0];
        end
    end

    // Next-state and next-output logic; outputs are registered from these.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        lat_n      = lat;
        lat_g_n    = lat_g;
        bus_dout_n = bus_dout;
        rdata_n    = rdata;
        rid_n      = rid;
        rvalid_n   = 1'b0;

        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_n    = ST_ADDR;
                    cnt_n      = HOLD_LD;
                    lat_n      = req_sel;
                    lat_g_n    = gidx;
                    // Upper nibble forced to zero keeps jt49_bus addr_ok set.
                    bus_dout_n = {4'h0, req_sel.addr};
                end
            end
            ST_ADDR: begin
                if (cnt == '0) begin
                    state_n = ST_GAP1;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            ST_GAP1: begin
                state_n = ST_DATA;
                cnt_n   = HOLD_LD;
                if (lat.we) begin
                    bus_dout_n = lat.data;
                end
            end
            ST_DATA: begin
                if (cnt == '0) begin
                    state_n = ST_GAP2;
                    // Last DATA cycle: jt49_bus dout has passed its cs_n register.
                    if (!lat.we) begin
                        rdata_n  = bus_din;
                        rid_n    = lat_g;
                        rvalid_n = 1'b1;
                    end
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            ST_GAP2: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        {bdir_n, bc1_n} = phase_code(state_n, lat_n.we);
        busy_n          = (state_n != ST_IDLE);
    end

    // State, latches and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            lat      <= '0;
            lat_g    <= 1'b0;
            bdir     <= 1'b0;
            bc1      <= 1'b0;
            bus_dout <= '0;
            rvalid   <= 1'b0;
            rid      <= 1'b0;
            rdata    <= '0;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            lat      <= lat_n;
            lat_g    <= lat_g_n;
            bdir     <= bdir_n;
            bc1      <= bc1_n;
            bus_dout <= bus_dout_n;
            rvalid   <= rvalid_n;
            rid      <= rid_n;
            rdata    <= rdata_n;
            busy     <= busy_n;
        end
    end

    // Simulation checks on parameter range and handshake sanity.
    always @(posedge clk) begin
        if (!rst) begin
            assert (HOLD >= 32'd1 && HOLD <= 32'd15)
                else $error("jt49_bus_sched: HOLD=%0d outside 1..15", HOLD);
            assert (!(accept && !req_sel.we && (HOLD < 32'd2)))
                else $error("jt49_bus_sched: read accepted with HOLD<2");
            assert (!(rvalid && req_ready[rid]))
                else $error("jt49_bus_sched: req_ready and rvalid on same port");
        end
    end

endmodule
